// File: rtl/button_event_queue.sv
// Debounced four-button press queue read by the CPU at address 7; each poll rise pops one colour event.
// Optional BTN_OVERFLOW_CLR_EN: overflow shown in data_out bit31 and cleared by a poll rise.
module button_event_queue #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DEPTH           = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     red_button,
   input  logic                     blue_button,
   input  logic                     green_button,
   input  logic                     yellow_button,
   input  logic                     poll,
   output logic [31:0]              data_out,
   output logic [$clog2(DEPTH):0]   pending_count,
   output logic                     overflow
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   // Bit index equals the colour code: 0 red, 1 blue, 2 green, 3 yellow.
   logic [3:0] raw;
   logic [3:0] pending_vec;
   logic [3:0] clear_sel;

   assign raw = {yellow_button, green_button, blue_button, red_button};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         logic          sync1_reg;
         logic          sync2_reg;
         logic          level_reg;
         logic          pending_reg;
         logic [CW-1:0] cnt_reg;
         logic          accept_rise;

         assign accept_rise     = sync2_reg & ~level_reg & (cnt_reg == CNT_MAX);
         assign pending_vec[gi] = pending_reg;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               sync1_reg   <= 1'b0;
               sync2_reg   <= 1'b0;
               level_reg   <= 1'b0;
               pending_reg <= 1'b0;
               cnt_reg     <= '0;
            end else begin
               sync1_reg <= raw[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == level_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_MAX) begin
                  cnt_reg   <= '0;
                  level_reg <= sync2_reg;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
               // A fresh press outranks clearing, so it is never lost behind an older push.
               if (accept_rise)
                  pending_reg <= 1'b1;
               else if (clear_sel[gi])
                  pending_reg <= 1'b0;
            end
         end
      end
   endgenerate

   logic            any_pending;
   logic [1:0]      win_idx;
   logic            poll_q_reg;
   logic            rise;
   logic            pop;
   logic            push;
   logic            drop;
   logic            empty;
   logic            full;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic            overflow_reg;
   logic [31:0]     snapshot_reg;
   logic [31:0]     head_word;
   logic [1:0]      mem [DEPTH];

   always_comb begin
      win_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending_vec[i])
            win_idx = 2'(i);
      end
   end

   assign any_pending = |pending_vec;
   assign clear_sel   = pending_vec & (~pending_vec + 4'd1);
   assign empty       = (count_reg == '0);
   assign full        = (count_reg == FULL_COUNT);
   assign rise        = poll & ~poll_q_reg;
   assign pop         = rise & ~empty;
   // A pop on the same edge frees the slot, so a full FIFO can still take the push.
   assign push        = any_pending & (~full | pop);
   assign drop        = any_pending & full & ~pop;

   always_comb begin
      head_word = 32'd0;
      if (!empty)
         head_word = {29'd0, 1'b1, mem[rd_ptr_reg]};
`ifdef BTN_OVERFLOW_CLR_EN
      head_word[31] = overflow_reg;
`endif
   end

   assign data_out      = (poll & poll_q_reg) ? snapshot_reg : head_word;
   assign pending_count = count_reg;
   assign overflow      = overflow_reg;

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr_reg] <= win_idx;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         poll_q_reg   <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         snapshot_reg <= 32'd0;
      end else begin
         poll_q_reg <= poll;
         if (rise)
            snapshot_reg <= head_word;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !pop)
            count_reg <= count_reg + 1'b1;
         else if (pop && !push)
            count_reg <= count_reg - 1'b1;
`ifdef BTN_OVERFLOW_CLR_EN
         if (drop)
            overflow_reg <= 1'b1;
         else if (rise)
            overflow_reg <= 1'b0;
`else
         if (drop)
            overflow_reg <= 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with DEBOUNCE_CYCLES=4, DEPTH=4.
module tb_button_event_queue;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        red_button = 1'b0;
   logic        blue_button = 1'b0;
   logic        green_button = 1'b0;
   logic        yellow_button = 1'b0;
   logic        poll = 1'b0;
   logic [31:0] data_out;
   logic [2:0]  pending_count;
   logic        overflow;

`ifdef BTN_OVERFLOW_CLR_EN
   localparam logic [31:0] OVF_W = 32'h8000_0000;
   localparam logic [31:0] OVF_STICKY = 32'd0;
`else
   localparam logic [31:0] OVF_W = 32'd0;
   localparam logic [31:0] OVF_STICKY = 32'd1;
`endif

   localparam logic [3:0] R = 4'b0001;
   localparam logic [3:0] B = 4'b0010;
   localparam logic [3:0] G = 4'b0100;
   localparam logic [3:0] Y = 4'b1000;

   button_event_queue #(.DEBOUNCE_CYCLES(4), .DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .red_button(red_button), .blue_button(blue_button),
      .green_button(green_button), .yellow_button(yellow_button),
      .poll(poll), .data_out(data_out),
      .pending_count(pending_count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  btn;
      logic        pl;
      logic [31:0] exp_data;
      logic [31:0] exp_count;
   } vec_t;

   vec_t vecs[25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic set_btn(input logic [3:0] b);
      {yellow_button, green_button, blue_button, red_button} = b;
   endtask

   task automatic poll_read(input string name, input logic [31:0] exp);
      cyc();
      poll = 1'b1;
      #2;
      $display("read %s data_out=%08h", name, data_out);
      chk(name, data_out, exp);
      cyc();
      poll = 1'b0;
   endtask

   task automatic press(input logic [3:0] b);
      cyc();
      set_btn(b);
      repeat (8) cyc();
      set_btn(4'd0);
      repeat (8) cyc();
   endtask

   function automatic vec_t mk(input logic [3:0] b, input logic p, input logic [31:0] d, input logic [31:0] c);
      vec_t v;
      v.btn = b; v.pl = p; v.exp_data = d; v.exp_count = c;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Green with two 2-cycle glitches, then held; accepted edge 14, pushed edge 15.
      vecs[0] = mk(G, 0, 0, 0); vecs[1] = mk(G, 0, 0, 0);
      vecs[2] = mk(0, 0, 0, 0); vecs[3] = mk(0, 0, 0, 0);
      vecs[4] = mk(G, 0, 0, 0); vecs[5] = mk(G, 0, 0, 0);
      vecs[6] = mk(0, 0, 0, 0); vecs[7] = mk(0, 0, 0, 0);
      for (int i = 8; i <= 14; i++) vecs[i] = mk(G, 0, 0, 0);
      for (int i = 15; i <= 17; i++) vecs[i] = mk(G, 0, 6, 1);
      vecs[18] = mk(G, 1, 6, 1);
      vecs[19] = mk(G, 1, 6, 0); vecs[20] = mk(G, 1, 6, 0);
      vecs[21] = mk(G, 0, 0, 0); vecs[22] = mk(G, 1, 0, 0);
      vecs[23] = mk(G, 0, 0, 0); vecs[24] = mk(G, 0, 0, 0);

      // Reset state and empty poll
      repeat (3) @(posedge clock);
      #2;
      chk("reset_data", data_out, 0);
      chk("reset_count", 32'(pending_count), 0);
      chk("reset_ovf", 32'(overflow), 0);
      reset = 1'b0;
      repeat (2) cyc();
      poll_read("empty_poll", 0);
      chk("empty_count", 32'(pending_count), 0);
      chk("empty_ovf", 32'(overflow), 0);

      // Table: glitchy green press and polls
      for (int i = 0; i < 25; i++) begin
         cyc();
         set_btn(vecs[i].btn);
         poll = vecs[i].pl;
         #2;
         chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
         chk($sformatf("vec%0d_count", i), 32'(pending_count), vecs[i].exp_count);
         chk($sformatf("vec%0d_ovf", i), 32'(overflow), 0);
      end
      set_btn(0);
      poll = 1'b0;
      repeat (10) cyc();
      chk("release_no_event", 32'(pending_count), 0);

      // Red and yellow accepted together
      cyc();
      set_btn(R | Y);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 6) chk("ry_k6_count", 32'(pending_count), 0);
         if (k == 7) chk("ry_k7_count", 32'(pending_count), 1);
         if (k == 7) chk("ry_k7_data", data_out, 4);
         if (k == 8) chk("ry_k8_count", 32'(pending_count), 2);
      end
      set_btn(0);
      repeat (8) cyc();
      chk("ry_after_release", 32'(pending_count), 2);
      cyc(); poll = 1'b1; #2;
      chk("hold_rise_data", data_out, 4);
      chk("hold_rise_count", 32'(pending_count), 2);
      cyc(); #2;
      chk("hold_c1_data", data_out, 4);
      chk("hold_c1_count", 32'(pending_count), 1);
      cyc(); #2;
      chk("hold_c2_data", data_out, 4);
      chk("hold_c2_count", 32'(pending_count), 1);
      cyc(); poll = 1'b0; #2;
      chk("hold_low_data", data_out, 7);
      poll_read("ry_second", 7);
      chk("ry_drained", 32'(pending_count), 0);

      // Five presses into a four-deep FIFO
      press(R); press(B); press(G); press(Y); press(R);
      chk("ovf_count", 32'(pending_count), 4);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_head", data_out, OVF_W | 32'd4);
      poll_read("ovf_read1", OVF_W | 32'd4);
      chk("ovf_after_read", 32'(overflow), OVF_STICKY);
      poll_read("ovf_read2", 5);
      poll_read("ovf_read3", 6);
      poll_read("ovf_read4", 7);
      poll_read("ovf_read5", 0);
      chk("ovf_final", 32'(overflow), OVF_STICKY);

      // Reset mid-debounce and during a high poll, green held through release
      press(B);
      cyc(); set_btn(G);
      cyc();
      cyc(); poll = 1'b1;
      cyc(); #1;
      chk("pre_reset_data", data_out, 5);
      reset = 1'b1;
      #1;
      chk("async_reset_data", data_out, 0);
      chk("async_reset_count", 32'(pending_count), 0);
      chk("async_reset_ovf", 32'(overflow), 0);
      cyc();
      poll = 1'b0;
      cyc();
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         if (k == 6) chk("rst_hold_k6_count", 32'(pending_count), 0);
         if (k == 7) chk("rst_hold_k7_count", 32'(pending_count), 1);
         if (k == 7) chk("rst_hold_k7_data", data_out, 6);
      end
      repeat (10) cyc();
      chk("rst_hold_once", 32'(pending_count), 1);
      set_btn(0);
      repeat (8) cyc();
      poll_read("rst_hold_read", 6);
      chk("rst_hold_drained", 32'(pending_count), 0);

      // Full FIFO: push and pop on the same edge
      press(R); press(B); press(G); press(Y);
      chk("full_count", 32'(pending_count), 4);
      cyc(); set_btn(R);
      for (int k = 1; k <= 7; k++) begin
         cyc();
         if (k == 6) begin
            poll = 1'b1;
            #2;
            chk("full_rise_head", data_out, 4);
         end
         if (k == 7) begin
            poll = 1'b0;
            #2;
            chk("full_pp_count", 32'(pending_count), 4);
            chk("full_pp_ovf", 32'(overflow), 0);
            chk("full_pp_head", data_out, 5);
         end
      end
      set_btn(0);
      repeat (8) cyc();
      poll_read("full_read1", 5);
      poll_read("full_read2", 6);
      poll_read("full_read3", 7);
      poll_read("full_read4", 4);
      chk("full_drained", 32'(pending_count), 0);
      chk("full_ovf_end", 32'(overflow), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
